float_argmax_reduce: RTL
========================

// Module: float_argmax_reduce
// PURPOSE
//  Streaming max/argmax reducer for IEEE-754 floats, one stage downstream of the float greater-than unit.
//  Consumes LEN samples after a run pulse; keeps the running maximum and its index.
//  Publishes the maximum, its index and a done mask for the accelerator datapath.
//  Ordering is identical to the greater-than unit, so both agree bit-for-bit.
// PARAMETERS
//  DATA_W  32  float word width
//  EXP_W    8  exponent width
//  IDX_W   16  index / length counter width
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       reset, asynchronous, active-low
//  running  in   1       accelerator run active; low forces IDLE
//  run      in   1       1-cycle start pulse; samples len
//  len      in   IDX_W   samples per reduction; 0 = empty reduction
//  in_valid in   1       in0 carries a sample this cycle
//  in0      in   DATA_W  sample
//  out0     out  DATA_W  running/final maximum
//  out1     out  DATA_W  index of maximum, zero-extended
//  out2     out  DATA_W  done mask: all-ones when result final, else 0
// BEHAVIOUR
//  Reset (rst=0): state=IDLE; out0, out1, out2, cnt, len_q, seen = 0.
//  States:
//   IDLE -> ACCUM on run with len!=0.
//   IDLE -> DONE on run with len==0: out0=0, out1=all-ones marks empty.
//   ACCUM -> DONE when accepted sample count reaches len_q.
//   DONE -> ACCUM on run with len!=0, or -> DONE again on run with len==0.
//   Any state -> IDLE when running=0; out0/out1 hold, out2 clears.
//  run in ACCUM aborts and restarts; partial result discarded.
//  On run: len_q=len, cnt=0, seen=0, out2=0.
//  In ACCUM, a sample is accepted when in_valid=1 (same-cycle run has priority; that sample is dropped):
//   - cnt++;
//   - if in0 is NaN (exp all-ones, mantissa!=0): out0/out1 unchanged.
//   - else if !seen or gt(in0,out0): out0=in0, out1=cnt (pre-increment), seen=1.
//  gt(a,b) ordering:
//   - both negative: magnitude less wins.
//   - same sign (positive): magnitude greater wins.
//   - mixed signs: positive wins, so +0 > -0.
//   - NaN on either side: false.
//  Ties keep the earliest index (strict compare).
//  Latency: out0/out1 update 1 cycle after an accepted sample.
//   out2 goes all-ones in the same cycle the last sample's result appears (1 cycle after the len_q-th accept).
//   out2 stays high until the next run or running=0.
//  All-NaN input: DONE with seen=0, out0=0, out1=all-ones (same as empty).
//  in_valid is ignored in IDLE and DONE.
//  cnt is IDX_W wide and never wraps: len_q <= 2^IDX_W-1, and DONE is entered at equality.
//  Mid-operation reset: immediate return to reset values; no sample is retained.
// STRUCTURE
//  Shared package float_pkg:
//   - DATA_W/EXP_W defaults
//   - is_nan(x) function
//   - state typedef {IDLE, ACCUM, DONE}
//  Sub-module float_gt_cmp (combinational a>b with the NaN rule).
//   Shares the ordering with the greater-than unit; instantiated once, comparing in0 vs out0.
//  Top level contains the FSM, the counter and the output registers only.
// TESTING
//  1. run, len=4; samples 1.0, 3.0, 2.0, 3.0 -> out0=0x40400000, out1=1, out2=all-ones 1 cycle after the 4th sample.
//  2. len=3; samples -2.0, -0.5, -7.0 -> out0=0xBF000000, out1=1.
//  3. len=2; samples -0.0, +0.0 -> out0=0x00000000, out1=1.
//  4. len=3; samples NaN 0x7FC00000, 5.0, NaN -> out0=0x40A00000, out1=1.
//     Then len=2, both samples NaN -> out0=0, out1=all-ones.
//  5. len=0 -> DONE next cycle, out1=all-ones.
//     Separately, len=5 with in_valid gaps: out2 rises only after 5 accepts.
//  6. rst low mid-ACCUM (after 2 of 4 samples) -> all outputs 0 at once, state IDLE.
//     Separately, run re-pulsed mid-ACCUM -> count restarts, earlier maximum discarded.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float definitions: default word format, NaN test and reducer state encoding.
package float_pkg;

   localparam int unsigned FP_DATA_W = 32;
   localparam int unsigned FP_EXP_W  = 8;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

   // NaN: exponent all-ones with a non-zero mantissa (infinities are ordinary values).
   function automatic logic is_nan(input logic [FP_DATA_W-1:0] x);
      return (&x[FP_DATA_W-2 -: FP_EXP_W]) && (|x[FP_DATA_W-FP_EXP_W-2:0]);
   endfunction

endpackage

// File: rtl/float_gt_cmp.sv
// Combinational a > b over IEEE-754 words; any NaN operand compares false.
module float_gt_cmp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned EXP_W  = 8
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_gt
);

   logic              w_a_nan;
   logic              w_b_nan;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [DATA_W-2:0] w_a_mag;
   logic [DATA_W-2:0] w_b_mag;

   assign w_a_nan = (&i_a[DATA_W-2 -: EXP_W]) && (|i_a[DATA_W-EXP_W-2:0]);
   assign w_b_nan = (&i_b[DATA_W-2 -: EXP_W]) && (|i_b[DATA_W-EXP_W-2:0]);
   assign w_a_neg = i_a[DATA_W-1];
   assign w_b_neg = i_b[DATA_W-1];
   assign w_a_mag = i_a[DATA_W-2:0];
   assign w_b_mag = i_b[DATA_W-2:0];

   // Mixed signs: the positive operand wins, which also orders +0 above -0.
   always_comb begin
      o_gt = 1'b0;
      if (!w_a_nan && !w_b_nan) begin
         if (w_a_neg != w_b_neg) begin
            o_gt = !w_a_neg;
         end else if (!w_a_neg) begin
            o_gt = w_a_mag > w_b_mag;
         end else begin
            o_gt = w_a_mag < w_b_mag;
         end
      end
   end

endmodule

// File: rtl/float_argmax_reduce.sv
// Streaming max/argmax reducer: after a run pulse, folds len samples into the running
// maximum and its index, then raises an all-ones done mask.
module float_argmax_reduce
   import float_pkg::*;
#(
   parameter int unsigned DATA_W = FP_DATA_W,
   parameter int unsigned EXP_W  = FP_EXP_W,
   parameter int unsigned IDX_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_running,
   input  logic              i_run,
   input  logic [IDX_W-1:0]  i_len,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in0,
   output logic [DATA_W-1:0] o_out0,
   output logic [DATA_W-1:0] o_out1,
   output logic [DATA_W-1:0] o_out2
);

   state_e             r_state,  w_state_nxt;
   logic [IDX_W-1:0]   r_cnt,    w_cnt_nxt;
   logic [IDX_W-1:0]   r_len,    w_len_nxt;
   logic               r_seen,   w_seen_nxt;
   logic               r_done,   w_done_nxt;
   logic [DATA_W-1:0]  r_out0,   w_out0_nxt;
   logic [DATA_W-1:0]  r_out1,   w_out1_nxt;
   logic [IDX_W-1:0]   w_cnt_inc;
   logic               w_in_nan;
   logic               w_gt;

   float_gt_cmp #(
      .DATA_W (DATA_W),
      .EXP_W  (EXP_W)
   ) u_gt (
      .i_a  (i_in0),
      .i_b  (r_out0),
      .o_gt (w_gt)
   );

   assign w_in_nan  = is_nan(i_in0);
   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_seen  <= 1'b0;
         r_done  <= 1'b0;
         r_out0  <= '0;
         r_out1  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_seen  <= w_seen_nxt;
         r_done  <= w_done_nxt;
         r_out0  <= w_out0_nxt;
         r_out1  <= w_out1_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_seen_nxt  = r_seen;
      w_done_nxt  = r_done;
      w_out0_nxt  = r_out0;
      w_out1_nxt  = r_out1;

      if (!i_running) begin
         w_state_nxt = IDLE;
         w_done_nxt  = 1'b0;
      end else if (i_run) begin
         // A run in any state restarts; a sample arriving with it is dropped.
         w_len_nxt  = i_len;
         w_cnt_nxt  = '0;
         w_seen_nxt = 1'b0;
         w_done_nxt = 1'b0;
         if (i_len == '0) begin
            w_state_nxt = DONE;
            w_out0_nxt  = '0;
            w_out1_nxt  = '1;
            w_done_nxt  = 1'b1;
         end else begin
            w_state_nxt = ACCUM;
         end
      end else if (r_state == ACCUM && i_in_valid) begin
         w_cnt_nxt = w_cnt_inc;
         if (!w_in_nan && (!r_seen || w_gt)) begin
            w_out0_nxt = i_in0;
            w_out1_nxt = DATA_W'(r_cnt);
            w_seen_nxt = 1'b1;
         end
         if (w_cnt_inc == r_len) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            // Nothing but NaNs: report the same result as an empty reduction.
            if (!w_seen_nxt) begin
               w_out0_nxt = '0;
               w_out1_nxt = '1;
            end
         end
      end
   end

   assign o_out0 = r_out0;
   assign o_out1 = r_out1;
   assign o_out2 = {DATA_W{r_done}};

endmodule
